// File: rtl/node_arb_pkg.sv
// Shared definitions for node_arbiter: FSM state encoding, default width and
// the timeout counter width rule.
package node_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_WIDTH = 16;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selection: first set request at or after the
// pointer, searching upward with wrap.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);
    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = SUM_W'(ptr) + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_arbiter.sv
// Round-robin arbiter sharing one ST/RD/IN/RES computation node among N_REQ
// requesters. Optional abort on a stuck node: define NODE_ARB_TIMEOUT_EN.
module node_arbiter
    import node_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DEF_WIDTH
`ifdef NODE_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       ACK,
    output logic [WIDTH-1:0]       RESULT,
    output logic                   BUSY,
    output logic                   ERR,
    output logic                   NODE_RST,
    output logic                   NODE_ST,
    output logic [WIDTH-1:0]       NODE_IN,
    input  logic                   NODE_RD,
    input  logic [WIDTH-1:0]       NODE_RES
);
    localparam int PTR_W = $clog2(N_REQ);

    state_t           state, next_state;
    logic [N_REQ-1:0] win, arb_req, pick_gnt;
    logic             pick_valid, start, to_hit, rst_done;
    logic [PTR_W-1:0] ptr, win_idx, ptr_next;
    logic [WIDTH-1:0] operand;
    logic [N_REQ-1:0] gnt_d, ack_d;
    logic             st_d, busy_d, err_d, nrst_d;

    assign arb_req = (state == DONE) ? (REQ & ~win) : REQ;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req  (arb_req),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .valid(pick_valid)
    );

    // No start while the node is held in reset, or its start edge would be lost.
    assign start = (state == IDLE) && pick_valid && !NODE_RST;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_gnt[i]) win_idx = PTR_W'(i);
    end

    assign operand  = REQ_DATA[int'(win_idx)*WIDTH +: WIDTH];
    assign ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef NODE_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                    cnt <= '0;
        else if (state == WAIT_LO || state == WAIT_HI) cnt <= cnt + 1'b1;
        else                                         cnt <= '0;
    end

    assign to_hit = ((state == WAIT_LO && NODE_RD) || (state == WAIT_HI && !NODE_RD))
                    && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = START;
            START:   next_state = WAIT_LO;
            WAIT_LO: if (to_hit) next_state = DONE;
                     else if (!NODE_RD) next_state = WAIT_HI;
            WAIT_HI: if (NODE_RD || to_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = start ? pick_gnt : '0;
        ack_d  = (next_state == DONE) ? win : '0;
        st_d   = (next_state == START);
        busy_d = (next_state != IDLE);
        err_d  = to_hit;
        nrst_d = !rst_done || to_hit;
    end

    // Every output is registered from the decoded next-cycle values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            GNT      <= '0;
            ACK      <= '0;
            RESULT   <= '0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
            NODE_RST <= 1'b1;
            NODE_ST  <= 1'b0;
            NODE_IN  <= '0;
            rst_done <= 1'b0;
            ptr      <= '0;
            win      <= '0;
        end else begin
            GNT      <= gnt_d;
            ACK      <= ack_d;
            BUSY     <= busy_d;
            ERR      <= err_d;
            NODE_RST <= nrst_d;
            NODE_ST  <= st_d;
            rst_done <= 1'b1;
            if (start) begin
                win     <= pick_gnt;
                ptr     <= ptr_next;
                NODE_IN <= operand;
            end
            if (to_hit)                          RESULT <= '0;
            else if (state == WAIT_HI && NODE_RD) RESULT <= NODE_RES;
        end
    end

endmodule
